// File: rtl/apple2_ram_arbiter_pkg.sv
// rtl/apple2_ram_arbiter_pkg.sv - shared encodings and defaults for the RAM arbiter
package apple2_ram_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    localparam logic [1:0] OWN_VID = 2'd0;
    localparam logic [1:0] OWN_CPU = 2'd1;
    localparam logic [1:0] OWN_DMA = 2'd2;

    localparam int ACC_CYC_DEF    = 2;
    localparam int STARVE_MAX_DEF = 4;

    function automatic logic [1:0] grant_owner(input logic [2:0] grant);
        if (grant[OWN_DMA]) return OWN_DMA;
        if (grant[OWN_CPU]) return OWN_CPU;
        return OWN_VID;
    endfunction

endpackage

// File: rtl/apple2_ram_prio.sv
// rtl/apple2_ram_prio.sv - one-hot requester selection for the RAM arbiter
module apple2_ram_prio
    import apple2_ram_arbiter_pkg::*;
(
    input  logic       vid_req_i,
    input  logic       cpu_req_i,
    input  logic       dma_req_i,
    input  logic       starve_full_i,
    output logic [2:0] grant_o
);

    // Video always wins; a starved DMA jumps ahead of the CPU only.
    always_comb begin
        grant_o = 3'b000;
        if (vid_req_i)                       grant_o[OWN_VID] = 1'b1;
        else if (dma_req_i && starve_full_i) grant_o[OWN_DMA] = 1'b1;
        else if (cpu_req_i)                  grant_o[OWN_CPU] = 1'b1;
        else if (dma_req_i)                  grant_o[OWN_DMA] = 1'b1;
    end

endmodule

// File: rtl/apple2_ram_arbiter.sv
// rtl/apple2_ram_arbiter.sv - time-shares the RAM port between video, CPU and DMA
module apple2_ram_arbiter
    import apple2_ram_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 18,
    parameter int ACC_CYC    = ACC_CYC_DEF,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic              mclk28,
    input  logic              reset_in,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_ack,
    output logic [7:0]        vid_rdata,
    output logic              vid_rvalid,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_wdata,
    input  logic              cpu_lc,
    input  logic              card_ram_we,
    input  logic              card_ram_rd,
    output logic              cpu_ack,
    output logic [7:0]        cpu_rdata,
    output logic              cpu_rvalid,
    output logic              cpu_rom,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [7:0]        dma_wdata,
    output logic              dma_ack,
    output logic [7:0]        dma_rdata,
    output logic              dma_rvalid,
    output logic              mem_cs,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_din,
    input  logic [7:0]        mem_dout
);

    localparam int         SW       = $clog2(STARVE_MAX + 1);
    localparam logic [2:0] LAST_CYC = 3'(ACC_CYC - 1);

    state_t            state_q, state_d;
    logic [2:0]        cyc_q;
    logic [SW-1:0]     starve_q;
    logic [1:0]        owner_q;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        wdata_q;
    logic              wr_q, mwe_q, rom_q;
    logic [7:0]        vid_rdata_q, cpu_rdata_q, dma_rdata_q;

    logic              starve_full;
    logic [2:0]        grant;
    logic              take;
    logic [ADDR_W-1:0] sel_addr;
    logic [7:0]        sel_wdata;
    logic              sel_wr, sel_mwe, sel_rom;

    assign starve_full = (starve_q == SW'(STARVE_MAX));

    apple2_ram_prio u_prio (
        .vid_req_i     (vid_req),
        .cpu_req_i     (cpu_req),
        .dma_req_i     (dma_req),
        .starve_full_i (starve_full),
        .grant_o       (grant)
    );

    assign take = (state_q == ST_IDLE) && (grant != 3'b000);

    always_comb begin
        sel_addr  = vid_addr;
        sel_wdata = 8'h00;
        sel_wr    = 1'b0;
        sel_mwe   = 1'b0;
        sel_rom   = 1'b0;
        if (grant[OWN_CPU]) begin
            sel_addr  = cpu_addr;
            sel_wdata = cpu_wdata;
            sel_wr    = cpu_we;
            // A protected card write still occupies a slot but never strobes mem_we.
            sel_mwe   = cpu_we && !(cpu_lc && !card_ram_we);
            sel_rom   = cpu_lc && !cpu_we && !card_ram_rd;
        end else if (grant[OWN_DMA]) begin
            sel_addr  = dma_addr;
            sel_wdata = dma_wdata;
            sel_wr    = dma_we;
            sel_mwe   = dma_we;
        end
    end

    always_ff @(posedge mclk28) begin
        if (reset_in) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (take) state_d = ST_ACCESS;
            ST_ACCESS: if (cyc_q == LAST_CYC) state_d = ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        vid_ack    = 1'b0;
        cpu_ack    = 1'b0;
        dma_ack    = 1'b0;
        vid_rvalid = 1'b0;
        cpu_rvalid = 1'b0;
        dma_rvalid = 1'b0;
        mem_cs     = 1'b0;
        mem_we     = 1'b0;
        if (!reset_in) begin
            case (state_q)
                ST_IDLE: begin
                    vid_ack = grant[OWN_VID];
                    cpu_ack = grant[OWN_CPU];
                    dma_ack = grant[OWN_DMA];
                end
                ST_ACCESS: begin
                    mem_cs = 1'b1;
                    mem_we = mwe_q;
                end
                ST_DONE: begin
                    vid_rvalid = !wr_q && (owner_q == OWN_VID);
                    cpu_rvalid = !wr_q && (owner_q == OWN_CPU);
                    dma_rvalid = !wr_q && (owner_q == OWN_DMA);
                end
                default: ;
            endcase
        end
    end

    assign cpu_rom   = cpu_rvalid && rom_q;
    assign mem_addr  = addr_q;
    assign mem_din   = wdata_q;
    assign vid_rdata = vid_rdata_q;
    assign cpu_rdata = cpu_rdata_q;
    assign dma_rdata = dma_rdata_q;

    always_ff @(posedge mclk28) begin
        if (reset_in) begin
            cyc_q       <= 3'd0;
            starve_q    <= '0;
            owner_q     <= OWN_VID;
            addr_q      <= '0;
            wdata_q     <= 8'h00;
            wr_q        <= 1'b0;
            mwe_q       <= 1'b0;
            rom_q       <= 1'b0;
            vid_rdata_q <= 8'h00;
            cpu_rdata_q <= 8'h00;
            dma_rdata_q <= 8'h00;
        end else begin
            if (take) begin
                owner_q <= grant_owner(grant);
                addr_q  <= sel_addr;
                wdata_q <= sel_wdata;
                wr_q    <= sel_wr;
                mwe_q   <= sel_mwe;
                rom_q   <= sel_rom;
                cyc_q   <= 3'd0;
            end
            if (state_q == ST_ACCESS) begin
                cyc_q <= cyc_q + 3'd1;
                if (cyc_q == LAST_CYC && !wr_q) begin
                    case (owner_q)
                        OWN_VID: vid_rdata_q <= mem_dout;
                        OWN_CPU: cpu_rdata_q <= mem_dout;
                        OWN_DMA: dma_rdata_q <= mem_dout;
                        default: ;
                    endcase
                end
            end
            if ((take && grant[OWN_DMA]) || !dma_req) starve_q <= '0;
            else if (take && grant[OWN_CPU] && !starve_full) starve_q <= starve_q + SW'(1);
        end
    end

endmodule

// File: tb/tb_apple2_ram_arbiter.sv
// tb/tb_apple2_ram_arbiter.sv - self-checking bench for the RAM arbiter
module tb_apple2_ram_arbiter;

    localparam int ACC  = 2;
    localparam int SMAX = 4;

    logic        mclk28 = 1'b0;
    logic        reset_in;
    logic        vid_req, vid_ack, vid_rvalid;
    logic [17:0] vid_addr;
    logic [7:0]  vid_rdata;
    logic        cpu_req, cpu_we, cpu_lc, card_ram_we, card_ram_rd;
    logic [17:0] cpu_addr;
    logic [7:0]  cpu_wdata, cpu_rdata;
    logic        cpu_ack, cpu_rvalid, cpu_rom;
    logic        dma_req, dma_we, dma_ack, dma_rvalid;
    logic [17:0] dma_addr;
    logic [7:0]  dma_wdata, dma_rdata;
    logic        mem_cs, mem_we;
    logic [17:0] mem_addr;
    logic [7:0]  mem_din, mem_dout;

    int checks   = 0;
    int failures = 0;

    apple2_ram_arbiter #(.ADDR_W(18), .ACC_CYC(ACC), .STARVE_MAX(SMAX)) dut (
        .mclk28(mclk28), .reset_in(reset_in),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack),
        .vid_rdata(vid_rdata), .vid_rvalid(vid_rvalid),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_lc(cpu_lc), .card_ram_we(card_ram_we), .card_ram_rd(card_ram_rd),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid), .cpu_rom(cpu_rom),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_ack(dma_ack), .dma_rdata(dma_rdata), .dma_rvalid(dma_rvalid),
        .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
        .mem_dout(mem_dout)
    );

    always #5 mclk28 = ~mclk28;

    // External RAM seen by the DUT, and the reference contents the model expects.
    logic [7:0] ram     [0:262143];
    logic [7:0] ref_mem [0:262143];

    function automatic logic [7:0] init_val(input logic [17:0] a);
        return a[7:0] ^ {a[11:8], a[15:12]} ^ {6'b0, a[17:16]} ^ 8'hC3;
    endfunction

    always @(negedge mclk28) mem_dout = ram[mem_addr];
    always @(posedge mclk28) if (mem_cs && mem_we) ram[mem_addr] <= mem_din;

    // Transaction-level reference: one access owns the port from grant until free_at.
    int          t = 0, free_at = 0, cs_lo = -1, cs_hi = -2, rv_at = -1, starve = 0;
    logic [1:0]  g_own = 2'd0;
    logic [17:0] g_addr = '0;
    logic [7:0]  g_din = '0, g_data = '0;
    logic        g_ewe = 1'b0, g_wr = 1'b0, g_rom = 1'b0;
    logic [2:0]  e_ack, e_rv;
    logic        e_cs, e_we;
    logic [42:0] e_word;

    task automatic model_eval();
        int w;
        e_ack = 3'b000;
        e_rv  = 3'b000;
        if (reset_in) begin
            free_at = t + 1; cs_lo = -1; cs_hi = -2; rv_at = -1; starve = 0;
        end else begin
            w = -1;
            if (t >= free_at) begin
                if (vid_req)                      w = 0;
                else if (dma_req && starve == SMAX) w = 2;
                else if (cpu_req)                 w = 1;
                else if (dma_req)                 w = 2;
            end
            if (w >= 0) begin
                e_ack[w] = 1'b1;
                g_own = 2'(w);
                g_rom = 1'b0;
                case (w)
                    0: begin g_addr = vid_addr; g_din = 8'h00; g_wr = 1'b0; g_ewe = 1'b0; end
                    1: begin
                        g_addr = cpu_addr; g_din = cpu_wdata; g_wr = cpu_we;
                        g_ewe  = cpu_we && (!cpu_lc || card_ram_we);
                        g_rom  = cpu_lc && !cpu_we && !card_ram_rd;
                    end
                    default: begin g_addr = dma_addr; g_din = dma_wdata; g_wr = dma_we; g_ewe = dma_we; end
                endcase
                g_data = ref_mem[g_addr];
                if (g_ewe) ref_mem[g_addr] = g_din;
                cs_lo = t + 1; cs_hi = t + ACC; rv_at = t + ACC + 1; free_at = t + ACC + 2;
            end
            if (w == 2 || !dma_req) starve = 0;
            else if (w == 1 && starve < SMAX) starve++;
        end
        e_cs = !reset_in && t >= cs_lo && t <= cs_hi;
        e_we = e_cs && g_ewe;
        if (!reset_in && t == rv_at && !g_wr) e_rv[g_own] = 1'b1;
        e_word = {e_ack, e_rv, e_cs, e_we, e_cs ? g_addr : 18'h0, e_we ? g_din : 8'h0,
                  (|e_rv) ? g_data : 8'h0, e_rv[1] ? g_rom : 1'b0};
        t++;
    endtask

    function automatic logic [42:0] obs_word();
        logic [7:0] rd;
        rd = e_rv[0] ? vid_rdata : e_rv[1] ? cpu_rdata : e_rv[2] ? dma_rdata : 8'h00;
        return {dma_ack, cpu_ack, vid_ack, dma_rvalid, cpu_rvalid, vid_rvalid, mem_cs, mem_we,
                e_cs ? mem_addr : 18'h0, e_we ? mem_din : 8'h0, rd, e_rv[1] ? cpu_rom : 1'b0};
    endfunction

    task automatic sample();
        @(negedge mclk28);
        model_eval();
    endtask

    task automatic advance();
        @(posedge mclk28);
        #1;
    endtask

    function automatic logic [17:0] rand_addr();
        return ($urandom_range(0, 1) ? 18'h0D000 : 18'h20400) + 18'($urandom_range(0, 7));
    endfunction

    task automatic test_reset();
        vid_req = 1'b1; cpu_req = 1'b1; dma_req = 1'b1;
        vid_addr = 18'h00111; cpu_addr = 18'h00222; dma_addr = 18'h00333;
        sample();
        checks++;
        if ({vid_ack, cpu_ack, dma_ack, vid_rvalid, cpu_rvalid, dma_rvalid, mem_cs, mem_we, mem_addr,
             mem_din, vid_rdata, cpu_rdata, dma_rdata, cpu_rom} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got ack=%b%b%b rv=%b%b%b cs=%b we=%b addr=%h din=%h required all zero",
                     vid_ack, cpu_ack, dma_ack, vid_rvalid, cpu_rvalid, dma_rvalid, mem_cs, mem_we, mem_addr, mem_din);
        end
        advance();
        reset_in = 1'b0; vid_req = 1'b0; cpu_req = 1'b0; dma_req = 1'b0;
        sample();
        checks++;
        if (obs_word() !== e_word) begin
            failures++;
            $display("FAIL reset_release: got %h required %h", obs_word(), e_word);
        end
        advance();
    endtask

    task automatic test_single_read();
        logic [2:0] tab [0:5];
        logic [2:0] acked;
        tab[0] = 3'b100; tab[1] = 3'b010; tab[2] = 3'b010;
        tab[3] = 3'b001; tab[4] = 3'b000; tab[5] = 3'b000;
        ram[18'h00400] = 8'h5A; ref_mem[18'h00400] = 8'h5A;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 18'h00400; cpu_lc = 1'b0;
        for (int i = 0; i < 6; i++) begin
            sample();
            checks++;
            if (obs_word() !== e_word) begin
                failures++;
                $display("FAIL single_read_model cyc%0d: got %h required %h", i, obs_word(), e_word);
            end
            checks++;
            if ({cpu_ack, mem_cs, cpu_rvalid} !== tab[i]) begin
                failures++;
                $display("FAIL single_read_timing cyc%0d: got %b required %b", i, {cpu_ack, mem_cs, cpu_rvalid}, tab[i]);
            end
            if (i == 3) begin
                checks++;
                if ({cpu_rdata, cpu_rom} !== {8'h5A, 1'b0}) begin
                    failures++;
                    $display("FAIL single_read_data: got %h rom=%b required 5a rom=0", cpu_rdata, cpu_rom);
                end
            end
            acked = e_ack;
            advance();
            if (acked[1]) cpu_req = 1'b0;
        end
    endtask

    task automatic test_simultaneous();
        int ack_cyc [3];
        logic [2:0] acked;
        ack_cyc = '{-1, -1, -1};
        vid_req = 1'b1; vid_addr = 18'h20010;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_lc = 1'b0; cpu_addr = 18'h00420;
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 18'h10030;
        for (int i = 0; i < 14; i++) begin
            sample();
            checks++;
            if (obs_word() !== e_word) begin
                failures++;
                $display("FAIL simultaneous_model cyc%0d: got %h required %h", i, obs_word(), e_word);
            end
            if (vid_ack && ack_cyc[0] < 0) ack_cyc[0] = i;
            if (cpu_ack && ack_cyc[1] < 0) ack_cyc[1] = i;
            if (dma_ack && ack_cyc[2] < 0) ack_cyc[2] = i;
            acked = e_ack;
            advance();
            if (acked[0]) vid_req = 1'b0;
            if (acked[1]) cpu_req = 1'b0;
            if (acked[2]) dma_req = 1'b0;
        end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (ack_cyc[k] != 4 * k) begin
                failures++;
                $display("FAIL simultaneous_order owner%0d: acked at cycle %0d required %0d", k, ack_cyc[k], 4 * k);
            end
        end
    endtask

    task automatic test_lc_protect();
        int cs_cnt, we_cnt, rv_cnt, din_bad;
        logic [2:0] acked;
        for (int p = 0; p < 2; p++) begin
            cs_cnt = 0; we_cnt = 0; rv_cnt = 0; din_bad = 0;
            cpu_req = 1'b1; cpu_we = 1'b1; cpu_lc = 1'b1; card_ram_we = p[0]; card_ram_rd = 1'b1;
            cpu_addr = 18'h0D000; cpu_wdata = 8'h3C + 8'(p);
            for (int i = 0; i < 6; i++) begin
                sample();
                checks++;
                if (obs_word() !== e_word) begin
                    failures++;
                    $display("FAIL lc_protect_model p%0d cyc%0d: got %h required %h", p, i, obs_word(), e_word);
                end
                cs_cnt += int'(mem_cs); we_cnt += int'(mem_we); rv_cnt += int'(cpu_rvalid);
                if (mem_we && mem_din !== 8'h3C + 8'(p)) din_bad++;
                acked = e_ack;
                advance();
                if (acked[1]) begin cpu_req = 1'b0; cpu_wdata = 8'hFF; card_ram_we = ~card_ram_we; end
            end
            checks++;
            if (cs_cnt != ACC || we_cnt != (p == 1 ? ACC : 0) || rv_cnt != 0 || din_bad != 0) begin
                failures++;
                $display("FAIL lc_protect p%0d: got cs=%0d we=%0d rv=%0d din_bad=%0d required cs=%0d we=%0d rv=0 din_bad=0",
                         p, cs_cnt, we_cnt, rv_cnt, din_bad, ACC, (p == 1 ? ACC : 0));
            end
        end
    endtask

    task automatic test_lc_rom();
        logic [2:0] acked;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_lc = 1'b1; card_ram_we = 1'b1; card_ram_rd = 1'b0;
        cpu_addr = 18'h0D010;
        for (int i = 0; i < 6; i++) begin
            sample();
            checks++;
            if (obs_word() !== e_word) begin
                failures++;
                $display("FAIL lc_rom_model cyc%0d: got %h required %h", i, obs_word(), e_word);
            end
            if (i == 3) begin
                checks++;
                if ({cpu_rvalid, cpu_rom} !== 2'b11) begin
                    failures++;
                    $display("FAIL lc_rom_flag: got rvalid=%b rom=%b required 1 1", cpu_rvalid, cpu_rom);
                end
            end
            acked = e_ack;
            advance();
            if (acked[1]) begin cpu_req = 1'b0; card_ram_rd = 1'b1; end
        end
    endtask

    task automatic test_starvation();
        int seq[$];
        int exp_seq [6];
        exp_seq = '{1, 1, 1, 1, 2, 1};
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_lc = 1'b0; cpu_addr = 18'h00500;
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 18'h10500; dma_wdata = 8'h77;
        for (int i = 0; i < 30; i++) begin
            sample();
            checks++;
            if (obs_word() !== e_word) begin
                failures++;
                $display("FAIL starvation_model cyc%0d: got %h required %h", i, obs_word(), e_word);
            end
            if (cpu_ack) seq.push_back(1);
            if (dma_ack) seq.push_back(2);
            advance();
            if (i == 22) begin cpu_req = 1'b0; dma_req = 1'b0; end
        end
        checks++;
        if (seq.size() < 6) begin
            failures++;
            $display("FAIL starvation_grants: got %0d grants required at least 6", seq.size());
        end else begin
            for (int k = 0; k < 6; k++) begin
                checks++;
                if (seq[k] != exp_seq[k]) begin
                    failures++;
                    $display("FAIL starvation_order grant%0d: got owner %0d required %0d", k, seq[k], exp_seq[k]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int rv_cnt;
        logic [2:0] acked;
        rv_cnt = 0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_lc = 1'b0; cpu_addr = 18'h00123;
        for (int i = 0; i < 10; i++) begin
            sample();
            checks++;
            if (obs_word() !== e_word) begin
                failures++;
                $display("FAIL reset_mid_model cyc%0d: got %h required %h", i, obs_word(), e_word);
            end
            rv_cnt += int'(cpu_rvalid);
            if (i == 1) begin
                checks++;
                if (mem_cs !== 1'b0) begin
                    failures++;
                    $display("FAIL reset_mid_cs: got %b required 0", mem_cs);
                end
            end
            if (i == 2) begin
                checks++;
                if (vid_ack !== 1'b1) begin
                    failures++;
                    $display("FAIL reset_mid_reack: got vid_ack=%b required 1", vid_ack);
                end
            end
            acked = e_ack;
            advance();
            if (i == 0) begin cpu_req = 1'b0; vid_req = 1'b1; vid_addr = 18'h20455; reset_in = 1'b1; end
            if (i == 1) reset_in = 1'b0;
            if (acked[0]) vid_req = 1'b0;
        end
        checks++;
        if (rv_cnt != 0) begin
            failures++;
            $display("FAIL reset_mid_rvalid: got %0d cpu_rvalid pulses required 0", rv_cnt);
        end
    endtask

    task automatic test_random();
        logic [2:0] acked;
        for (int i = 0; i < 600; i++) begin
            sample();
            checks++;
            if (obs_word() !== e_word) begin
                failures++;
                $display("FAIL random_model cyc%0d: got %h required %h", i, obs_word(), e_word);
            end
            acked = e_ack;
            advance();
            if (acked[0] || (vid_req && $urandom_range(0, 15) == 0)) begin
                vid_req = 1'b0; vid_addr = rand_addr();
            end else if (!vid_req && $urandom_range(0, 7) == 0) begin
                vid_req = 1'b1; vid_addr = rand_addr();
            end
            if (acked[1] || (cpu_req && $urandom_range(0, 15) == 0)) begin
                cpu_req = 1'b0; cpu_addr = rand_addr(); cpu_we = 1'($urandom_range(0, 1));
                cpu_lc = 1'($urandom_range(0, 1)); card_ram_we = 1'($urandom_range(0, 1));
                card_ram_rd = 1'($urandom_range(0, 1)); cpu_wdata = 8'($urandom);
            end else if (!cpu_req && $urandom_range(0, 1) == 0) begin
                cpu_req = 1'b1; cpu_addr = rand_addr(); cpu_we = 1'($urandom_range(0, 1));
                cpu_lc = 1'($urandom_range(0, 1)); card_ram_we = 1'($urandom_range(0, 1));
                card_ram_rd = 1'($urandom_range(0, 1)); cpu_wdata = 8'($urandom);
            end
            if (acked[2] || (dma_req && $urandom_range(0, 15) == 0)) begin
                dma_req = 1'b0; dma_addr = rand_addr(); dma_we = 1'($urandom_range(0, 1));
                dma_wdata = 8'($urandom);
            end else if (!dma_req && $urandom_range(0, 2) == 0) begin
                dma_req = 1'b1; dma_addr = rand_addr(); dma_we = 1'($urandom_range(0, 1));
                dma_wdata = 8'($urandom);
            end
        end
        vid_req = 1'b0; cpu_req = 1'b0; dma_req = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int a = 0; a < 262144; a++) begin
            ram[a]     = init_val(18'(a));
            ref_mem[a] = init_val(18'(a));
        end
        reset_in = 1'b1;
        vid_req = 1'b0; vid_addr = '0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        cpu_lc = 1'b0; card_ram_we = 1'b0; card_ram_rd = 1'b1;
        dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
        repeat (3) @(posedge mclk28);
        #1;
        test_reset();
        test_single_read();
        test_simultaneous();
        test_lc_protect();
        test_lc_rom();
        test_starvation();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
